uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. Captures each completed received word on a one-cycle done strobe and checks parity against the active config. Stores data plus a parity-error flag in a circular FIFO. Presents entries to the host/bus side over a valid/ready handshake and keeps a sticky overflow flag.

---
 rtl/uart_rx_fifo_pkg.sv | 46 ++++
 rtl/uart_rx_fifo_mem.sv | 36 +++
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receive path.
//
// config_t    : active line configuration (word length select, parity enable/sense).
// rx_entry_t  : one FIFO entry, received data byte plus its parity-error flag.
// wr_state_t  : write-side FSM state of uart_rx_fifo; separate from the receiver's own
//               state type.
// decode_word : extracts data/parity from a raw receiver word and checks parity.
package uart_rx_fifo_pkg;

    typedef struct packed {
        logic word;     // 1: 8 data bits, 0: 7 data bits
        logic par_en;   // parity bit present and checked
        logic par_odd;  // 1: odd parity, 0: even parity
    } config_t;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } rx_entry_t;

    typedef enum logic {
        CAP,
        WR
    } wr_state_t;

    // The parity bit sits directly after the last data bit. In 7-bit mode bit 8 is
    // outside the frame and ignored. The data MSB is forced to 0 there, so the XOR
    // reduction over all 8 bits still covers only the real data bits.
    function automatic rx_entry_t decode_word(input config_t cfg, input logic [8:0] w);
        rx_entry_t  e;
        logic [7:0] d;
        logic       p;
        if (cfg.word) begin
            d = w[7:0];
            p = w[8];
        end else begin
            d = {1'b0, w[6:0]};
            p = w[7];
        end
        e.data = d;
        // Total ones (data + parity) is odd exactly when the XOR is 1.
        e.perr = cfg.par_en && ((^d ^ p) != cfg.par_odd);
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for uart_rx_fifo: DEPTH x rx_entry_t registers, one synchronous
// write port, one asynchronous read port. The array is not reset; validity is
// tracked by the pointers and count in the parent.
//
// Ports:
//   clk   : system clock
//   we    : write enable; wdata is stored at waddr on the rising edge
//   waddr : write address
//   wdata : entry to store
//   raddr : read address
//   rdata : entry at raddr (combinational)
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rx_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output rx_entry_t     rdata
);

    rx_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer placed directly after the UART receiver.
//
// Each rx_done strobe captures rx_word. Data and the parity bit are split out
// according to rx_cfg, and parity is checked at that point (stage S0). On the
// following edge the entry is written into a circular FIFO (stage S1). If the FIFO
// is full and nothing is popped in that cycle, the word is dropped and the sticky
// overflow flag is set. The head entry goes to the consumer over valid/ready.
//
// Optional feature (macro UART_RX_FIFO_THRESH_EN): adds a fill-level threshold
// input and a registered interrupt output.
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   rx_cfg   : active line config, sampled only when rx_done is high
//   rx_word  : receiver word, LSB first in arrival order
//   rx_done  : one-cycle strobe marking rx_word valid
//   rd_data  : head entry data (0 when empty)
//   rd_perr  : head entry parity-error flag (0 when empty)
//   rd_valid : FIFO not empty
//   rd_ready : consumer pops the head when rd_valid && rd_ready
//   full     : FIFO holds DEPTH entries
//   overflow : sticky, set when a word is dropped
//   ovf_clr  : clears overflow (a simultaneous new overflow wins)
//   thresh   : [UART_RX_FIFO_THRESH_EN] fill level threshold, 0 disables
//   thr_irq  : [UART_RX_FIFO_THRESH_EN] registered count >= thresh
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  config_t     rx_cfg,
    input  logic [8:0]  rx_word,
    input  logic        rx_done,
    output logic [7:0]  rd_data,
    output logic        rd_perr,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        full,
    output logic        overflow,
    input  logic        ovf_clr
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    input  logic [AW:0] thresh,
    output logic        thr_irq
`endif
);

    localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [AW:0]   CntOne  = (AW + 1)'(1);

    // Write side: capture stage (S0) and FSM
    wr_state_t state_q;
    rx_entry_t cap_q;
    logic      cap_vld;

    // WR lasts exactly one cycle per captured word. A strobe arriving while in WR
    // keeps the FSM in WR, so back-to-back strobes give one write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAP;
            cap_q   <= '0;
        end else begin
            if (rx_done) begin
                cap_q <= decode_word(rx_cfg, rx_word);
            end
            unique case (state_q)
                CAP: if (rx_done)  state_q <= WR;
                WR:  if (!rx_done) state_q <= CAP;
            endcase
        end
    end

    assign cap_vld = (state_q == WR);

    // Pointers, count and overflow (S1 and read side)
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          pop, wr_en, drop;
    rx_entry_t     head;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == FullCnt);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign wr_en    = cap_vld && (!full || pop);
    assign drop     = cap_vld && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (wr_en && !pop) begin
                count_q <= count_q + CntOne;
            end else if (pop && !wr_en) begin
                count_q <= count_q - CntOne;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign overflow = overflow_q;

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (cap_q),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // The array itself is not reset. Masking with rd_valid gives 0 outputs from
    // reset and whenever the FIFO is empty.
    assign rd_data = rd_valid ? head.data : '0;
    assign rd_perr = rd_valid && head.perr;

`ifdef UART_RX_FIFO_THRESH_EN
    logic thr_irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_irq_q <= 1'b0;
        end else begin
            thr_irq_q <= (thresh != '0) && (count_q >= thresh);
        end
    end

    assign thr_irq = thr_irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo. Stimulus pushes the expected {perr, data}
// of every word that should be stored. The monitor pops and compares on every
// accepted read (sampled on the falling edge).
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    config_t    rx_cfg;
    logic [8:0] rx_word;
    logic       rx_done;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_valid;
    logic       rd_ready;
    logic       full;
    logic       overflow;
    logic       ovf_clr;
`ifdef UART_RX_FIFO_THRESH_EN
    logic [$clog2(DEPTH):0] thresh = '0;
    logic                   thr_irq;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q [$];  // {perr, data}
    logic [8:0] expv;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_cfg   (rx_cfg),
        .rx_word  (rx_word),
        .rx_done  (rx_done),
        .rd_data  (rd_data),
        .rd_perr  (rd_perr),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_THRESH_EN
        ,
        .thresh   (thresh),
        .thr_irq  (thr_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] w, input logic [7:0] d, input logic p, input bit push);
        rx_word = w;
        rx_done = 1'b1;
        if (push) exp_q.push_back({p, d});
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted read must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0h want none", {rd_perr, rd_data});
            end else begin
                expv = exp_q.pop_front();
                check("pop_entry", 32'({rd_perr, rd_data}), 32'(expv));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rx_cfg   = '0;
        rx_word  = '0;
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_perr", 32'(rd_perr), 32'd0);
        rst = 1'b0;
        tick();

        // 1: basic write, two-cycle latency, pop
        rx_cfg = '{word: 1'b1, par_en: 1'b0, par_odd: 1'b0};
        send(9'h0A5, 8'hA5, 1'b0, 1'b1);
        check("lat_n1_valid", 32'(rd_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(rd_valid), 32'd1);
        check("lat_n2_data", 32'(rd_data), 32'hA5);
        check("lat_n2_perr", 32'(rd_perr), 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pop_empty", 32'(rd_valid), 32'd0);

        // 2: 8-bit even parity
        rx_cfg   = '{word: 1'b1, par_en: 1'b1, par_odd: 1'b0};
        rd_ready = 1'b1;
        send(9'h103, 8'h03, 1'b1, 1'b1);
        send(9'h003, 8'h03, 1'b0, 1'b1);
        wait_drain("drain_t2");

        // 3: 7-bit odd parity; rx_word[8] ignored; cfg change after capture
        rx_cfg = '{word: 1'b0, par_en: 1'b1, par_odd: 1'b1};
        send(9'h1C1, 8'h41, 1'b0, 1'b1);
        rx_cfg = '{word: 1'b1, par_en: 1'b1, par_odd: 1'b0};
        tick();
        rx_cfg = '{word: 1'b0, par_en: 1'b1, par_odd: 1'b1};
        send(9'h041, 8'h41, 1'b1, 1'b1);
        wait_drain("drain_t3");
        rd_ready = 1'b0;

        // 4: fill, overflow, clear, set-wins
        rx_cfg = '{word: 1'b1, par_en: 1'b0, par_odd: 1'b0};
        for (int i = 1; i <= 16; i++) begin
            send(9'(i), 8'(i), 1'b0, 1'b1);
        end
        check("not_full_15", 32'(full), 32'd0);
        send(9'd17, 8'd17, 1'b0, 1'b0);
        check("full_16", 32'(full), 32'd1);
        check("no_ovf_yet", 32'(overflow), 32'd0);
        tick();
        check("ovf_17", 32'(overflow), 32'd1);
        check("full_held", 32'(full), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        send(9'h012, 8'h12, 1'b0, 1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr2", 32'(overflow), 32'd0);

        // 5: write and pop in the same cycle while full
        send(9'h055, 8'h55, 1'b0, 1'b1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("full_wr_pop", 32'(full), 32'd1);
        check("no_ovf_wr_pop", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        wait_drain("drain_t5");
        check("empty_t5", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;

        // 6: asynchronous reset with 5 entries stored
        for (int i = 0; i < 5; i++) begin
            send(9'(8'hE0 + i), 8'hE0, 1'b0, 1'b0);
        end
        tick();
        tick();
        check("pre_rst_valid", 32'(rd_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rd_valid), 32'd0);
        check("async_rst_full", 32'(full), 32'd0);
        check("async_rst_data", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send(9'h03C, 8'h3C, 1'b0, 1'b1);
        rd_ready = 1'b1;
        wait_drain("drain_t6");
        check("empty_t6", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
